// File: rtl/mult.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/finish handshake.
// Latency depends on the highest set bit of in2 (0 cycles when in2 is zero).
module mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    output logic [15:0] out,
    output logic        finish
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [15:0] a, a_n;
    logic [7:0]  b, b_n;
    logic [15:0] acc, acc_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] out_n;
    logic        finish_n;
    logic [15:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            finish <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            b      <= b_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            out    <= out_n;
            finish <= finish_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a;
        b_n      = b;
        acc_n    = acc;
        cnt_n    = cnt;
        out_n    = out;
        finish_n = 1'b0;
        sum      = acc + (b[0] ? a : 16'd0);

        case (state)
            IDLE: begin
                if (start) begin
                    if (in2 != 8'd0) begin
                        a_n     = {8'd0, in1};
                        b_n     = in2;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = CALC;
                    end else begin
                        out_n    = '0;
                        finish_n = 1'b1;
                    end
                end
            end
            CALC: begin
                a_n   = a << 1;
                b_n   = b >> 1;
                cnt_n = cnt + 4'd1;
                // Stop once no multiplier bits remain above the one just consumed.
                if (b[7:1] == 7'd0 || cnt == 4'd7) begin
                    out_n    = sum;
                    finish_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    acc_n = sum;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: stimulus pushes expected product and completion edge,
// a negedge monitor pops and compares whenever finish is seen.
module tb_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [15:0] out;
    logic        finish;

    mult dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .out    (out),
        .finish (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] prod;
        int unsigned fin_cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_out = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned lat_of(input logic [7:0] m);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 8; i++)
            if (m[i]) n = i + 1;
        return n;
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = out;
        end else if (finish) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish actual=finish out=%0d expected=no finish (cyc %0d)", out, cyc);
            end else begin
                e = q.pop_front();
                check("product", out, e.prod);
                check("finish_edge", cyc, e.fin_cyc);
            end
            last_out = out;
        end else begin
            check("out_hold", out, last_out);
            if (q.size() != 0 && cyc > q[0].fin_cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_finish actual=none expected=finish at edge %0d (cyc %0d)", q[0].fin_cyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    // Must be called at a negedge; returns at the negedge of the finish cycle.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit perturb);
        int unsigned acc_e;
        int unsigned target;
        exp_t e;
        in1 = x;
        in2 = y;
        start = 1'b1;
        acc_e = cyc + 1;
        target = acc_e + lat_of(y);
        e.prod = 16'(x) * 16'(y);
        e.fin_cyc = target;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        if (perturb) begin
            in1 = 8'h11;
            in2 = 8'h22;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        int unsigned a0;
        exp_t e;
        logic [7:0] rx, ry;

        rst_n = 1'b0;
        start = 1'b0;
        in1 = '0;
        in2 = '0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_finish", finish, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd34, 8'd12, 0);          // 408, 4 cycles
        repeat (3) @(negedge clk);       // out must hold 408
        do_op(8'd255, 8'd255, 0);        // 65025, 8 cycles
        do_op(8'd255, 8'd1, 0);          // 255, 1 cycle
        do_op(8'd77, 8'd0, 0);           // 0, finish on accepting edge
        do_op(8'd0, 8'd128, 0);          // 0, 8 cycles
        do_op(8'd13, 8'd11, 0);          // 143, 4 cycles

        // Continuous start: second op accepted in the finish cycle of the first.
        in1 = 8'd3;
        in2 = 8'd5;
        start = 1'b1;
        a0 = cyc + 1;
        e.prod = 16'd15; e.fin_cyc = a0 + 3; q.push_back(e);
        e.prod = 16'd15; e.fin_cyc = a0 + 7; q.push_back(e);
        while (cyc < a0 + 4) @(negedge clk);
        start = 1'b0;
        in1 = 8'd9;
        in2 = 8'd9;
        while (cyc < a0 + 7) @(negedge clk);

        do_op(8'd255, 8'd255, 1);        // operand change and start pulse mid-CALC ignored
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-CALC of 200x200; no finish may follow.
        in1 = 8'd200;
        in2 = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out", out, 0);
        check("async_reset_finish", finish, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(8'd6, 8'd7, 0);            // 42

        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            if (i % 16 == 0) ry = 8'($urandom_range(0, 3));
            do_op(rx, ry, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
